// File: rtl/sobel_line_buffer_if.sv
// Pixel stream bundle between the raster source, the line buffer and the Sobel window stage.
interface sobel_line_buffer_if #(
    parameter int WIDTH = 24
);
    logic             valid_in;
    logic             sof;
    logic [WIDTH-1:0] din;
    logic             valid_out;
    logic             eol_out;
    logic [WIDTH-1:0] dout1;
    logic [WIDTH-1:0] dout2;
    logic [WIDTH-1:0] dout3;

    modport master (
        output valid_in, sof, din,
        input  valid_out, eol_out, dout1, dout2, dout3
    );

    modport slave (
        input  valid_in, sof, din,
        output valid_out, eol_out, dout1, dout2, dout3
    );
endinterface

// File: rtl/sobel_line_buffer.sv
// Two-line buffer presenting vertically aligned 3-pixel columns to the Sobel window stage.
// valid_out is withheld until two full lines of the current frame have been stored.
module sobel_line_buffer #(
    parameter int PIC_WIDTH  = 250,
    parameter int PIC_HEIGHT = 250,
    parameter int WIDTH      = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sobel_line_buffer_if.slave   bus
);
    localparam int CW = $clog2(PIC_WIDTH);
    localparam int RW = $clog2(PIC_HEIGHT);

    logic [WIDTH-1:0] line_a [PIC_WIDTH];
    logic [WIDTH-1:0] line_b [PIC_WIDTH];

    logic [CW-1:0]    col_cnt_q, col_cnt_d;
    logic [RW-1:0]    row_cnt_q, row_cnt_d;
    logic [CW-1:0]    addr;
    logic [RW-1:0]    row_eff;
    logic             valid_q, valid_d;
    logic             eol_q, eol_d;
    logic [WIDTH-1:0] dout1_q, dout2_q, dout3_q;

    // sof forces the effective position to (0,0); the normal advance rule then yields col 1, row 0.
    always_comb begin
        addr      = bus.sof ? '0 : col_cnt_q;
        row_eff   = bus.sof ? '0 : row_cnt_q;
        col_cnt_d = col_cnt_q;
        row_cnt_d = row_cnt_q;
        valid_d   = 1'b0;
        eol_d     = 1'b0;
        if (bus.valid_in) begin
            if (addr == CW'(PIC_WIDTH - 1)) begin
                col_cnt_d = '0;
                row_cnt_d = (row_eff == RW'(PIC_HEIGHT - 1)) ? '0 : row_eff + 1'b1;
            end else begin
                col_cnt_d = addr + 1'b1;
                row_cnt_d = row_eff;
            end
            valid_d = (row_eff >= RW'(2));
            eol_d   = valid_d && (addr == CW'(PIC_WIDTH - 1));
        end
    end

    // Line memories carry no reset so they map onto block RAM (read-before-write).
    always_ff @(posedge clk) begin
        if (bus.valid_in) begin
            line_a[addr] <= bus.din;
            line_b[addr] <= line_a[addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_cnt_q <= '0;
            row_cnt_q <= '0;
            valid_q   <= 1'b0;
            eol_q     <= 1'b0;
            dout1_q   <= '0;
            dout2_q   <= '0;
            dout3_q   <= '0;
        end else begin
            col_cnt_q <= col_cnt_d;
            row_cnt_q <= row_cnt_d;
            valid_q   <= valid_d;
            eol_q     <= eol_d;
            if (bus.valid_in) begin
                dout3_q <= bus.din;
                dout2_q <= line_a[addr];
                dout1_q <= line_b[addr];
            end
        end
    end

    assign bus.valid_out = valid_q;
    assign bus.eol_out   = eol_q;
    assign bus.dout1     = dout1_q;
    assign bus.dout2     = dout2_q;
    assign bus.dout3     = dout3_q;
endmodule

// File: tb/tb_sobel_line_buffer.sv
// Bench for sobel_line_buffer on a 4x4 image: directed raster sequences plus a randomized tail,
// checked against a frame-image model that looks up rows r-2 / r-1 by pixel coordinates.
module tb_sobel_line_buffer;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int DW = 24;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sobel_line_buffer_if #(.WIDTH(DW)) bus ();

    sobel_line_buffer #(
        .PIC_WIDTH (W),
        .PIC_HEIGHT(H),
        .WIDTH     (DW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference: pixels of the current frame indexed by (row, col), plus the raster position.
    logic [DW-1:0] pix [H][W];
    int            mr = 0;
    int            mc = 0;
    logic          exp_v = 1'b0;
    logic          exp_eol = 1'b0;
    logic [DW-1:0] exp_d1 = '0;
    logic [DW-1:0] exp_d2 = '0;
    logic [DW-1:0] exp_d3 = '0;
    logic          d12_known = 1'b1;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        chk("valid_out", DW'(bus.valid_out), DW'(exp_v));
        chk("eol_out",   DW'(bus.eol_out),   DW'(exp_eol));
        chk("dout3",     bus.dout3,          exp_d3);
        if (d12_known) begin
            chk("dout1", bus.dout1, exp_d1);
            chk("dout2", bus.dout2, exp_d2);
        end
    endtask

    task automatic step(input logic v, input logic s, input logic [DW-1:0] d);
        bus.valid_in = v;
        bus.sof      = s;
        bus.din      = d;
        if (v) begin
            if (s) begin
                mr = 0;
                mc = 0;
            end
            exp_v   = (mr >= 2);
            exp_eol = exp_v && (mc == W - 1);
            exp_d3  = d;
            if (exp_v) begin
                exp_d1    = pix[mr-2][mc];
                exp_d2    = pix[mr-1][mc];
                d12_known = 1'b1;
            end else begin
                d12_known = 1'b0;
            end
            pix[mr][mc] = d;
            mc++;
            if (mc == W) begin
                mc = 0;
                mr = (mr == H - 1) ? 0 : mr + 1;
            end
        end else begin
            exp_v   = 1'b0;
            exp_eol = 1'b0;
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_reset(input int unsigned cycles);
        rst_n        = 1'b0;
        bus.valid_in = 1'b0;
        bus.sof      = 1'b0;
        bus.din      = '0;
        repeat (cycles) @(posedge clk);
        #1;
        mr = 0;
        mc = 0;
        exp_v = 1'b0;
        exp_eol = 1'b0;
        exp_d1 = '0;
        exp_d2 = '0;
        exp_d3 = '0;
        d12_known = 1'b1;
        check_outputs();
        rst_n = 1'b1;
    endtask

    // Stream pixels (r,c) from (r0,c0) up to but excluding (r1,c1), value = base + r*16 + c.
    task automatic stream(input int r0, input int c0, input int r1, input int c1,
                          input logic [DW-1:0] base);
        for (int p = r0 * W + c0; p < r1 * W + c1; p++) begin
            step(1'b1, (p == 0), base + DW'((p / W) * 16 + (p % W)));
        end
    endtask

    initial begin
        bus.valid_in = 1'b0;
        bus.sof      = 1'b0;
        bus.din      = '0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                pix[r][c] = '0;

        do_reset(2);

        // Frame 1: priming rows, then alignment with a 3-cycle gap after (2,1).
        stream(0, 0, 2, 0, 24'h0);
        stream(2, 0, 2, 2, 24'h0);
        chk("align21_d1", bus.dout1, 24'h01);
        chk("align21_d2", bus.dout2, 24'h11);
        chk("align21_d3", bus.dout3, 24'h21);
        repeat (3) step(1'b0, 1'b0, 24'hdead);
        chk("gap_hold_d1", bus.dout1, 24'h01);
        chk("gap_hold_d2", bus.dout2, 24'h11);
        step(1'b0, 1'b1, 24'hbeef);
        stream(2, 2, 2, 3, 24'h0);
        chk("after_gap_d1", bus.dout1, 24'h02);
        chk("after_gap_d3", bus.dout3, 24'h22);
        stream(2, 3, 4, 0, 24'h0);
        chk("last_eol", DW'(bus.eol_out), DW'(1));
        chk("last_d1", bus.dout1, 24'h13);

        // Frame 2 with +0x40: priming must not leak frame-1 data.
        stream(0, 0, 2, 1, 24'h40);
        chk("f2_d1", bus.dout1, 24'h40);
        chk("f2_d2", bus.dout2, 24'h50);
        chk("f2_d3", bus.dout3, 24'h60);

        // Mid-row sof resync, then 8 valid pixels with no valid_out.
        step(1'b1, 1'b1, 24'h80);
        for (int i = 1; i < 12; i++) step(1'b1, 1'b0, 24'h80 + DW'(i));
        chk("resync_valid", DW'(bus.valid_out), DW'(1));

        // Reset mid-row 3, then re-prime without sof.
        stream(0, 0, 3, 2, 24'h100);
        do_reset(1);
        for (int i = 0; i < 3 * W; i++) step(1'b1, 1'b0, 24'h200 + DW'(i));

        // Random tail: random gaps, data and occasional sof.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 40) == 0), DW'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $error("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
